float8_mul_arbiter: RTL and testbench
=====================================

Name: float8_mul_arbiter

Overview:
- Shares one combinational Float8Mult instance (1 sign, 3 exponent, 4 mantissa bits) among N_REQ requesters in the TPU datapath.
- Round-robin grant, two-stage registered pipeline (issue, response), per-requester valid/ready handshakes.
- Cleans up the multiplier's overflow flag and optionally saturates on overflow.
- Keeps a saturating overflow event counter for debug readout.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SAT_ON_OVF, 1, 1: on overflow the result is {sign, 7'h7F}; 0: iMulProd is passed through unchanged.
- CNT_W, 16, width of the overflow event counter.

Ports:
- iClk  in  1  clock, rising edge.
- iRst_n  in  1  synchronous active-low reset.
- iReqValid  in  N_REQ  per-requester request valid.
- iReqA  in  8*N_REQ  operand A; requester k uses bits [8k+7:8k].
- iReqB  in  8*N_REQ  operand B; same packing as iReqA.
- oReqReady  out  N_REQ  one-hot grant; request k is accepted when iReqValid[k] & oReqReady[k].
- oMulA  out  8  to Float8Mult iNum1; driven from the stage-1 register.
- oMulB  out  8  to Float8Mult iNum2; driven from the stage-1 register.
- iMulProd  in  8  from Float8Mult oNum.
- iMulOvf  in  1  from Float8Mult overflow.
- oRespValid  out  N_REQ  one-hot response valid, addressed to the original requester.
- iRespReady  in  N_REQ  per-requester response ready.
- oRespData  out  8  product.
- oRespOvf  out  1  product overflowed.
- oOvfCount  out  CNT_W  saturating count of overflowed responses.

Behaviour:
- Single clock domain; reset is synchronous and active-low. All state updates occur only on rising iClk.
- Reset (iRst_n=0 at an edge):
  - s1_valid=0, s2_valid=0, rr_ptr=0, oOvfCount=0.
  - oRespValid=0, oRespData=0, oRespOvf=0, oMulA=0, oMulB=0.
  - oReqReady is forced to 0 while iRst_n=0.
  - Reset mid-operation discards in-flight stage-1/stage-2 transactions; no response is ever issued for them.
- Stage 2 (response register):
  - s2_fire = s2_valid & iRespReady[s2_id].
  - s2_free = ~s2_valid | s2_fire.
- Stage 1 (issue register): s1_adv = s1_valid & s2_free. Stage 1 accepts when ~s1_valid | s1_adv.
- Arbitration is combinational:
  - When stage 1 can accept, grant the first k with iReqValid[k]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - oReqReady is one-hot or zero, and is 0 when stage 1 cannot accept.
  - oReqReady may depend combinationally on iReqValid.
- On an accepted request (grant k):
  - Load s1_a, s1_b from requester k's slice; set s1_id=k, s1_valid=1.
  - rr_ptr <= (k+1) mod N_REQ. rr_ptr is unchanged when nothing is granted.
- If stage 1 advances with no new grant, s1_valid <= 0.
- oMulA/oMulB = s1_a/s1_b. The multiplier is combinational and sampled in the same cycle as s1_adv.
- On s1_adv:
  - zero = (s1_a[6:0]==0) | (s1_b[6:0]==0).
  - ovf = iMulOvf & ~zero. The multiplier's overflow is undefined for zero operands, so it is masked.
  - data = 8'h00 if zero. Otherwise {s1_a[7]^s1_b[7], 7'h7F} if ovf and SAT_ON_OVF=1. Otherwise iMulProd.
  - s2 <= {data, ovf, s1_id}; s2_valid <= 1.
  - If ovf and oOvfCount != all-ones, oOvfCount increments; it holds at all-ones.
- If s2_fire occurs with no s1_adv, s2_valid <= 0.
- oRespValid = s2_valid ? one-hot(s2_id) : 0. oRespData/oRespOvf hold stable while oRespValid is high and unacknowledged.
- Latency: accept at edge T, oRespValid high after edge T+1 (two cycles from request to response with no backpressure).
- Throughput: one product per cycle under continuous ready; simultaneous s2_fire and s1_adv in the same cycle is legal.
- Backpressure: a stalled stage 2 stalls stage 1, which deasserts all oReqReady. At most 2 transactions are in flight.
- Responses to different requesters are returned in acceptance order; no reordering.

Test Plan:
- Single request, no backpressure: requester 0 sends A=0x40, B=0x40; multiplier model returns 0x40, ovf=0 -> oRespValid=4'b0001 two cycles later, oRespData=0x40, oRespOvf=0.
- All 4 requesters valid continuously, all iRespReady=1 -> grants cycle 0,1,2,3,0,... one per cycle; responses in the same order at full rate.
- Overflow with SAT_ON_OVF=1: A=0xFF, B=0x7F; model returns ovf=1 -> oRespData=0xFF, oRespOvf=1, oOvfCount=1. Repeat 3 more times -> oOvfCount=4.
- Zero operand: A=0x80, B=0x55; model forced iMulOvf=1, prod=0x33 -> oRespData=0x00, oRespOvf=0, oOvfCount unchanged.
- Backpressure: iRespReady[1]=0 for 5 cycles with requests pending -> oRespValid[1] and oRespData held stable, oReqReady=0 after stage 1 fills. On release, the two queued results drain in order on consecutive cycles.
- Reset mid-operation: iRst_n=0 for one edge with both stages full -> all outputs 0, no stale response afterwards, and the first post-reset grant goes to requester 0 (rr_ptr=0).

Source files
------------

// File: rtl/float8_mul_arbiter.sv
// Round-robin arbiter sharing one combinational Float8Mult among N_REQ requesters.
// Two registered stages: issue (drives the multiplier) and response (held until acked).
module float8_mul_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter bit          SAT_ON_OVF = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic [N_REQ-1:0]     iReqValid,
    input  logic [8*N_REQ-1:0]   iReqA,
    input  logic [8*N_REQ-1:0]   iReqB,
    output logic [N_REQ-1:0]     oReqReady,
    output logic [7:0]           oMulA,
    output logic [7:0]           oMulB,
    input  logic [7:0]           iMulProd,
    input  logic                 iMulOvf,
    output logic [N_REQ-1:0]     oRespValid,
    input  logic [N_REQ-1:0]     iRespReady,
    output logic [7:0]           oRespData,
    output logic                 oRespOvf,
    output logic [CNT_W-1:0]     oOvfCount
);

    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SUM_W = ID_W + 1;

    // Stage-1 (issue) state
    logic              s1_valid;
    logic [7:0]        s1_a;
    logic [7:0]        s1_b;
    logic [ID_W-1:0]   s1_id;

    // Stage-2 (response) state; data/ovf live directly in the output registers
    logic              s2_valid;
    logic [ID_W-1:0]   s2_id;

    logic [ID_W-1:0]   rr_ptr;

    // Handshake / arbitration signals
    logic              s2_fire;
    logic              s2_free;
    logic              s1_adv;
    logic              s1_accept;
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic              grant;
    logic [ID_W-1:0]   rr_next;
    logic [SUM_W-1:0]  scan_sum;
    logic [ID_W-1:0]   scan_idx;

    // Cleaned-up multiplier result
    logic              mul_zero;
    logic              mul_ovf;
    logic [7:0]        mul_data;

    logic [7:0]        req_a [N_REQ];
    logic [7:0]        req_b [N_REQ];

    // Unpack the flat operand buses into per-requester bytes
    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            req_a[k] = iReqA[8*k +: 8];
            req_b[k] = iReqB[8*k +: 8];
        end
    end

    assign s2_fire   = s2_valid & iRespReady[s2_id];
    assign s2_free   = ~s2_valid | s2_fire;
    assign s1_adv    = s1_valid & s2_free;
    assign s1_accept = ~s1_valid | s1_adv;

    // Round-robin search starting at rr_ptr, wrapping modulo N_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_sum = SUM_W'(rr_ptr) + SUM_W'(i);
            if (scan_sum >= SUM_W'(N_REQ)) begin
                scan_sum = scan_sum - SUM_W'(N_REQ);
            end
            scan_idx = ID_W'(scan_sum);
            if (!grant_found && iReqValid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    assign grant   = iRst_n & s1_accept & grant_found;
    assign rr_next = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // One-hot ready toward the winning requester, zero when stage 1 is blocked
    always_comb begin
        oReqReady = '0;
        if (grant) begin
            oReqReady[grant_id] = 1'b1;
        end
    end

    // Zero operands make the multiplier's overflow meaningless, so mask it
    always_comb begin
        mul_zero = (s1_a[6:0] == 7'h00) | (s1_b[6:0] == 7'h00);
        mul_ovf  = iMulOvf & ~mul_zero;
        if (mul_zero) begin
            mul_data = 8'h00;
        end else if (mul_ovf && SAT_ON_OVF) begin
            mul_data = {s1_a[7] ^ s1_b[7], 7'h7F};
        end else begin
            mul_data = iMulProd;
        end
    end

    // Issue stage: capture the granted operands and advance the round-robin pointer
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            rr_ptr   <= '0;
        end else if (grant) begin
            s1_valid <= 1'b1;
            s1_a     <= req_a[grant_id];
            s1_b     <= req_b[grant_id];
            s1_id    <= grant_id;
            rr_ptr   <= rr_next;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Response stage: sample the multiplier as stage 1 advances, hold until acked
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            s2_valid  <= 1'b0;
            s2_id     <= '0;
            oRespData <= '0;
            oRespOvf  <= 1'b0;
        end else if (s1_adv) begin
            s2_valid  <= 1'b1;
            s2_id     <= s1_id;
            oRespData <= mul_data;
            oRespOvf  <= mul_ovf;
        end else if (s2_fire) begin
            s2_valid  <= 1'b0;
        end
    end

    // Saturating overflow event counter for debug
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            oOvfCount <= '0;
        end else if (s1_adv && mul_ovf && (oOvfCount != '1)) begin
            oOvfCount <= oOvfCount + CNT_W'(1);
        end
    end

    // Response valid addressed back to the originating requester
    always_comb begin
        oRespValid = '0;
        if (s2_valid) begin
            oRespValid[s2_id] = 1'b1;
        end
    end

    assign oMulA = s1_a;
    assign oMulB = s1_b;

endmodule

// File: tb/tb_float8_mul_arbiter.sv
// Directed bench for float8_mul_arbiter with a simple stand-in multiplier.
module tb_float8_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a_bus;
    logic [31:0] req_b_bus;
    logic [3:0]  req_ready;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [7:0]  mul_prod;
    logic        mul_ovf;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready;
    logic [7:0]  resp_data;
    logic        resp_ovf;
    logic [15:0] ovf_count;

    logic [7:0]  ra [4];
    logic [7:0]  rb [4];
    logic        force_en;
    logic [7:0]  force_prod;
    logic        force_ovf;

    int passed = 0;
    int total  = 0;

    logic [3:0] g_tab [8];
    logic [7:0] d_tab [8];

    always #5 clk = ~clk;

    // Pack per-requester operands onto the flat buses
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            req_a_bus[8*k +: 8] = ra[k];
            req_b_bus[8*k +: 8] = rb[k];
        end
    end

    // Stand-in multiplier: prod = a^b^0x40, overflow when both magnitudes are 0x7F
    assign mul_prod = force_en ? force_prod : (mul_a ^ mul_b ^ 8'h40);
    assign mul_ovf  = force_en ? force_ovf
                               : ((mul_a[6:0] == 7'h7F) && (mul_b[6:0] == 7'h7F));

    float8_mul_arbiter #(.N_REQ(4), .SAT_ON_OVF(1'b1), .CNT_W(16)) dut (
        .iClk       (clk),
        .iRst_n     (rst_n),
        .iReqValid  (req_valid),
        .iReqA      (req_a_bus),
        .iReqB      (req_b_bus),
        .oReqReady  (req_ready),
        .oMulA      (mul_a),
        .oMulB      (mul_b),
        .iMulProd   (mul_prod),
        .iMulOvf    (mul_ovf),
        .oRespValid (resp_valid),
        .iRespReady (resp_ready),
        .oRespData  (resp_data),
        .oRespOvf   (resp_ovf),
        .oOvfCount  (ovf_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        g_tab = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        d_tab = '{8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        force_en   = 1'b0;
        force_prod = 8'h00;
        force_ovf  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ra[k] = 8'h00;
            rb[k] = 8'h00;
        end

        // Reset state
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", 32'(resp_data), 32'h0);
        chk("rst_resp_ovf", 32'(resp_ovf), 32'h0);
        chk("rst_mul_a", 32'(mul_a), 32'h0);
        chk("rst_mul_b", 32'(mul_b), 32'h0);
        chk("rst_count", 32'(ovf_count), 32'h0);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        tick();

        // Single request from requester 0
        ra[0] = 8'h40; rb[0] = 8'h40;
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("single_mul_a", 32'(mul_a), 32'h40);
        chk("single_resp_early", 32'(resp_valid), 32'h0);
        tick();
        chk("single_resp_valid", 32'(resp_valid), 32'h1);
        chk("single_resp_data", 32'(resp_data), 32'h40);
        chk("single_resp_ovf", 32'(resp_ovf), 32'h0);
        tick();
        chk("single_resp_done", 32'(resp_valid), 32'h0);

        // All requesters continuously valid: round robin from rr_ptr=1 at full rate
        for (int k = 0; k < 4; k++) begin
            ra[k] = 8'h10 + 8'(k);
            rb[k] = 8'h40;
        end
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("rr_grant", 32'(req_ready), 32'(g_tab[i]));
            if (i >= 2) begin
                chk("rr_resp_valid", 32'(resp_valid), 32'(g_tab[i-2]));
                chk("rr_resp_data", 32'(resp_data), 32'(d_tab[i-2]));
            end else begin
                chk("rr_resp_idle", 32'(resp_valid), 32'h0);
            end
            tick();
        end
        req_valid = 4'b0000;
        #1;
        chk("rr_tail6_valid", 32'(resp_valid), 32'(g_tab[6]));
        chk("rr_tail6_data", 32'(resp_data), 32'(d_tab[6]));
        tick();
        chk("rr_tail7_valid", 32'(resp_valid), 32'(g_tab[7]));
        chk("rr_tail7_data", 32'(resp_data), 32'(d_tab[7]));
        tick();
        chk("rr_drained", 32'(resp_valid), 32'h0);

        // Overflow with saturation: requester 1, 0xFF * 0x7F
        ra[1] = 8'hFF; rb[1] = 8'h7F;
        req_valid = 4'b0010;
        #1;
        chk("ovf_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("ovf_resp_valid", 32'(resp_valid), 32'h2);
        chk("ovf_resp_data", 32'(resp_data), 32'hFF);
        chk("ovf_resp_ovf", 32'(resp_ovf), 32'h1);
        chk("ovf_count1", 32'(ovf_count), 32'h1);
        for (int r = 0; r < 3; r++) begin
            req_valid = 4'b0010;
            tick();
            req_valid = 4'b0000;
            tick();
            chk("ovf_rep_data", 32'(resp_data), 32'hFF);
            chk("ovf_rep_count", 32'(ovf_count), 32'(2 + r));
        end

        // Positive saturation: requester 2, 0x7F * 0x7F
        ra[2] = 8'h7F; rb[2] = 8'h7F;
        req_valid = 4'b0100;
        #1;
        chk("pos_sat_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("pos_sat_valid", 32'(resp_valid), 32'h4);
        chk("pos_sat_data", 32'(resp_data), 32'h7F);
        chk("pos_sat_count", 32'(ovf_count), 32'h5);

        // Zero operand masks a spurious overflow: requester 3, 0x80 * 0x55
        force_en = 1'b1; force_prod = 8'h33; force_ovf = 1'b1;
        ra[3] = 8'h80; rb[3] = 8'h55;
        req_valid = 4'b1000;
        #1;
        chk("zero_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("zero_valid", 32'(resp_valid), 32'h8);
        chk("zero_data", 32'(resp_data), 32'h00);
        chk("zero_ovf", 32'(resp_ovf), 32'h0);
        chk("zero_count", 32'(ovf_count), 32'h5);
        force_en = 1'b0;
        tick();

        // Backpressure on requester 1's response
        ra[1] = 8'h21; rb[1] = 8'h40;
        ra[2] = 8'h22; rb[2] = 8'h40;
        ra[3] = 8'h23; rb[3] = 8'h40;
        resp_ready = 4'b1101;
        req_valid  = 4'b1110;
        #1;
        chk("bp_grant1", 32'(req_ready), 32'h2);
        tick();
        chk("bp_grant2", 32'(req_ready), 32'h4);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_low", 32'(req_ready), 32'h0);
            chk("bp_hold_valid", 32'(resp_valid), 32'h2);
            chk("bp_hold_data", 32'(resp_data), 32'h21);
            tick();
        end
        req_valid  = 4'b0000;
        resp_ready = 4'b1111;
        #1;
        chk("bp_release_valid", 32'(resp_valid), 32'h2);
        chk("bp_release_data", 32'(resp_data), 32'h21);
        tick();
        chk("bp_drain_valid", 32'(resp_valid), 32'h4);
        chk("bp_drain_data", 32'(resp_data), 32'h22);
        tick();
        chk("bp_drained", 32'(resp_valid), 32'h0);

        // Reset with both stages full
        ra[0] = 8'h31; rb[0] = 8'h40;
        resp_ready = 4'b0000;
        req_valid  = 4'b1111;
        tick();
        tick();
        chk("full_resp_valid", 32'(resp_valid), 32'h8);
        chk("full_ready", 32'(req_ready), 32'h0);
        chk("full_mul_a", 32'(mul_a), 32'h31);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready_forced", 32'(req_ready), 32'h0);
        tick();
        chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
        chk("midrst_resp_data", 32'(resp_data), 32'h0);
        chk("midrst_mul_a", 32'(mul_a), 32'h0);
        chk("midrst_count", 32'(ovf_count), 32'h0);
        rst_n      = 1'b1;
        resp_ready = 4'b1111;
        #1;
        chk("postrst_grant0", 32'(req_ready), 32'h1);
        req_valid = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst_no_stale", 32'(resp_valid), 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
